freq_gate_ctrl: RTL

Gate-time controller and result latch for the BCD frequency meter. Sits upstream of the 6-digit BCD pulse counter. Drives that counter's ENA (count window) and CLR (clear) inputs from the system clock. After each window it captures the counter's 24-bit BCD output into a stable register for the display/readout stage, together with the range used.

---
 rtl/freq_meter_pkg.sv | 35 +++
 rtl/freq_gate_timer.sv | 41 ++++
 rtl/freq_gate_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the BCD frequency meter.
// Holds the gate-controller state encoding, the BCD result geometry and the
// GATE_SEL window encodings used by the gate controller and the pulse counter.
package freq_meter_pkg;

    localparam int unsigned BCD_DIGITS = 6;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4
    } gate_state_t;

    // Window length select encodings
    localparam logic [1:0] GSEL_1X     = 2'd0;  // GATE_CYCLES
    localparam logic [1:0] GSEL_DIV10  = 2'd1;  // GATE_CYCLES/10
    localparam logic [1:0] GSEL_DIV100 = 2'd2;  // GATE_CYCLES/100
    localparam logic [1:0] GSEL_RSVD   = 2'd3;  // behaves as GSEL_1X

    // Map a raw select to the range actually used; the reserved code means 1x.
    function automatic logic [1:0] eff_gate_sel(input logic [1:0] sel);
        logic [1:0] eff;
        case (sel)
            GSEL_1X:     eff = GSEL_1X;
            GSEL_DIV10:  eff = GSEL_DIV10;
            GSEL_DIV100: eff = GSEL_DIV100;
            default:     eff = GSEL_1X;
        endcase
        return eff;
    endfunction

endpackage

// File: rtl/freq_gate_timer.sv
// Loadable down-counter used for the CLR, GATE and SETTLE intervals.
// Loading value N-1 makes done_o rise after N cycles in the loading state.
// The counter stops at zero; it never wraps.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (counter -> RST_VAL)
//   load_i     load load_val_i this cycle
//   load_val_i interval length minus one
//   done_o     counter is at zero
module freq_gate_timer #(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    localparam logic [W-1:0] ONE  = W'(1'b1);
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] cnt_q;

    // Count down towards zero, reload on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != ZERO) begin
            cnt_q <= cnt_q - ONE;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign done_o = (cnt_q == ZERO);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-time controller and result latch for the BCD frequency meter.
// Sequences CLEAR -> GATE -> SETTLE -> LATCH -> CLEAR (IDLE when RUN is low),
// driving the pulse counter's ENA/CLR and capturing its BCD output.
// Ports:
//   CLK, RST_N   system clock / asynchronous active-low reset
//   RUN          1 = measure continuously, 0 = stop after current cycle
//   GATE_SEL     window select (0: 1x, 1: /10, 2: /100, 3: as 0)
//   Q_IN         BCD count from the pulse counter
//   ENA, CLR     count enable / clear to the pulse counter
//   DOUT, RANGE  latched result and the range it was measured with
//   VALID        one-cycle pulse when DOUT/RANGE update
//   BUSY         high whenever not IDLE
// All outputs are registered from the next-state value.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned GATE_CYCLES   = 50_000_000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CLR_CYCLES    = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RUN,
    input  logic [1:0]       GATE_SEL,
    input  logic [BCD_W-1:0] Q_IN,
    output logic             ENA,
    output logic             CLR,
    output logic [BCD_W-1:0] DOUT,
    output logic [1:0]       RANGE,
    output logic             VALID,
    output logic             BUSY
);

    localparam int unsigned TW = $clog2(GATE_CYCLES + 1);

    // Timer load values are interval length minus one
    localparam logic [TW-1:0] LEN_1X     = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] LEN_DIV10  = TW'(GATE_CYCLES / 10 - 1);
    localparam logic [TW-1:0] LEN_DIV100 = TW'(GATE_CYCLES / 100 - 1);
    localparam logic [TW-1:0] LEN_CLR    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] LEN_SETTLE = TW'(SETTLE_CYCLES - 1);

    // Named marker block that only exists for an illegal parameter set
    if (CLK_HZ == 0 || GATE_CYCLES % 100 != 0 || SETTLE_CYCLES < 2 || CLR_CYCLES < 1) begin : g_bad_params
    end

    gate_state_t      state_q, state_d;
    logic [1:0]       range_q, range_d;
    logic             tmr_load_s;
    logic [TW-1:0]    tmr_val_s;
    logic             tmr_done_s;

    logic             ena_q, clr_q, valid_q, busy_q;
    logic [BCD_W-1:0] dout_q;
    logic [1:0]       range_out_q;

    function automatic logic [TW-1:0] gate_len(input logic [1:0] eff_sel);
        logic [TW-1:0] len;
        case (eff_sel)
            GSEL_DIV10:  len = LEN_DIV10;
            GSEL_DIV100: len = LEN_DIV100;
            default:     len = LEN_1X;
        endcase
        return len;
    endfunction

    freq_gate_timer #(
        .W       (TW),
        .RST_VAL (LEN_CLR)
    ) u_timer (
        .clk        (CLK),
        .rst_n      (RST_N),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .done_o     (tmr_done_s)
    );

    // Next-state, range capture and interval timer loading
    always_comb begin
        state_d    = state_q;
        range_d    = range_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = LEN_CLR;
        case (state_q)
            ST_CLEAR: begin
                if (tmr_done_s) begin
                    if (RUN) begin
                        // GATE_SEL is only looked at here, on GATE entry
                        state_d    = ST_GATE;
                        range_d    = eff_gate_sel(GATE_SEL);
                        tmr_load_s = 1'b1;
                        tmr_val_s  = gate_len(eff_gate_sel(GATE_SEL));
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (RUN) begin
                    state_d    = ST_CLEAR;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LEN_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (tmr_done_s) begin
                    state_d    = ST_SETTLE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = LEN_SETTLE;
                end else begin
                    state_d = ST_GATE;
                end
            end
            ST_SETTLE: begin
                if (tmr_done_s) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_LATCH: begin
                state_d    = ST_CLEAR;
                tmr_load_s = 1'b1;
                tmr_val_s  = LEN_CLR;
            end
            default: begin
                state_d    = ST_CLEAR;
                tmr_load_s = 1'b1;
                tmr_val_s  = LEN_CLR;
            end
        endcase
    end

    // State register plus outputs registered from the next state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_CLEAR;
            range_q     <= GSEL_1X;
            ena_q       <= 1'b0;
            clr_q       <= 1'b1;
            valid_q     <= 1'b0;
            busy_q      <= 1'b1;
            dout_q      <= {BCD_W{1'b0}};
            range_out_q <= GSEL_1X;
        end else begin
            state_q <= state_d;
            range_q <= range_d;
            ena_q   <= (state_d == ST_GATE);
            clr_q   <= (state_d == ST_CLEAR);
            valid_q <= (state_d == ST_LATCH);
            busy_q  <= (state_d != ST_IDLE);
            // Capture on the edge into LATCH so DOUT and VALID appear together;
            // Q_IN has been static for the whole SETTLE interval by then.
            if (state_d == ST_LATCH) begin
                dout_q      <= Q_IN;
                range_out_q <= range_q;
            end else begin
                dout_q      <= dout_q;
                range_out_q <= range_out_q;
            end
        end
    end

    assign ENA   = ena_q;
    assign CLR   = clr_q;
    assign VALID = valid_q;
    assign BUSY  = busy_q;
    assign DOUT  = dout_q;
    assign RANGE = range_out_q;

endmodule
